// File: rtl/aircon_pkg.sv
// Shared types for the multi-zone air-conditioning controller: zone state
// encoding (legacy S0/S1/S2 values kept) and the global mode codes.
package aircon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10,
        HOLD = 2'b11
    } zone_state_e;

    localparam logic [1:0] MODE_OFF       = 2'b00;
    localparam logic [1:0] MODE_HEAT_ONLY = 2'b01;
    localparam logic [1:0] MODE_COOL_ONLY = 2'b10;
    localparam logic [1:0] MODE_AUTO      = 2'b11;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aircon_zone_fsm.sv
// One zone: demand comparators on the registered sample, the
// idle/heat/cool/hold state register and the shared dwell counter.
module aircon_zone_fsm
    import aircon_pkg::*;
#(
    parameter int TEMP_W  = 8,
    parameter int MIN_RUN = 16,
    parameter int LOCKOUT = 32
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic signed [TEMP_W-1:0] temp,
    input  logic signed [TEMP_W-1:0] setpoint,
    input  logic        [TEMP_W-2:0] hyst,
    input  logic        [1:0]        mode,
    input  logic                     grant,
    input  logic                     force_off,
    output zone_state_e              state,
    output logic                     req
);

    localparam int CNT_MAX = max2(max2(MIN_RUN, LOCKOUT), 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EXT_W   = TEMP_W + 2;
    localparam logic [CNT_W-1:0] RUN_END  = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(LOCKOUT);
    localparam zone_state_e EXIT_STATE = (LOCKOUT == 0) ? IDLE : HOLD;

    zone_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two extra bits of headroom keep setpoint +/- hyst exact at the range ends.
    logic signed [EXT_W-1:0] t_x, sp_x, hy_x, lo_x, hi_x;
    logic heat_req, cool_req, at_target;

    assign t_x  = {{2{temp[TEMP_W-1]}}, temp};
    assign sp_x = {{2{setpoint[TEMP_W-1]}}, setpoint};
    assign hy_x = {3'b000, hyst};
    assign lo_x = sp_x - hy_x;
    assign hi_x = sp_x + hy_x;

    assign heat_req = (t_x < lo_x) && ((mode == MODE_HEAT_ONLY) || (mode == MODE_AUTO));
    assign cool_req = (t_x > hi_x) && ((mode == MODE_COOL_ONLY) || (mode == MODE_AUTO));
    assign req      = heat_req || cool_req;
    assign state    = state_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        at_target = (state_q == HEAT) ? (t_x >= sp_x) : (t_x <= sp_x);
        case (state_q)
            IDLE: begin
                if (grant && !force_off && req) begin
                    state_d = heat_req ? HEAT : COOL;
                    cnt_d   = '0;
                end
            end
            HEAT, COOL: begin
                if (cnt_q != RUN_END) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Force-off skips the minimum run but still goes through lockout.
                if (force_off || (at_target && (cnt_q == RUN_END))) begin
                    state_d = EXIT_STATE;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/aircon_multizone_ctrl.sv
// Multi-zone heat/cool controller top: sample registers, per-zone FSMs,
// ascending-index grant chain under the active-zone cap, and LED decode.
module aircon_multizone_ctrl
    import aircon_pkg::*;
#(
    parameter int N_ZONES    = 4,
    parameter int TEMP_W     = 8,
    parameter int MIN_RUN    = 16,
    parameter int LOCKOUT    = 32,
    parameter int MAX_ACTIVE = 2
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [N_ZONES*TEMP_W-1:0]     temp,
    input  logic [N_ZONES*TEMP_W-1:0]     setpoint,
    input  logic [TEMP_W-2:0]             hyst,
    input  logic [1:0]                    mode,
    input  logic [N_ZONES-1:0]            zone_en,
    output logic [N_ZONES-1:0]            LR,
    output logic [N_ZONES-1:0]            LG,
    output logic [$clog2(N_ZONES+1)-1:0]  active_count
);

    localparam int AC_W = $clog2(N_ZONES + 1);

    logic [N_ZONES*TEMP_W-1:0] temp_q, temp_d, sp_q, sp_d;
    zone_state_e               state [N_ZONES];
    logic [N_ZONES-1:0]        req, want, grant, force_off, active;

    always_comb begin
        temp_d = temp_q;
        sp_d   = sp_q;
        if (sample_valid) begin
            temp_d = temp;
            sp_d   = setpoint;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            temp_q <= '0;
            sp_q   <= '0;
        end else begin
            temp_q <= temp_d;
            sp_q   <= sp_d;
        end
    end

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
        assign force_off[i] = (mode == MODE_OFF) || !zone_en[i];

        aircon_zone_fsm #(
            .TEMP_W  (TEMP_W),
            .MIN_RUN (MIN_RUN),
            .LOCKOUT (LOCKOUT)
        ) u_fsm (
            .clock     (clock),
            .rst       (rst),
            .temp      (temp_q[i*TEMP_W +: TEMP_W]),
            .setpoint  (sp_q[i*TEMP_W +: TEMP_W]),
            .hyst      (hyst),
            .mode      (mode),
            .grant     (grant[i]),
            .force_off (force_off[i]),
            .state     (state[i]),
            .req       (req[i])
        );

        assign want[i]   = (state[i] == IDLE) && req[i] && !force_off[i];
        assign active[i] = (state[i] == HEAT) || (state[i] == COOL);
        assign LR[i]     = (state[i] == HEAT);
        assign LG[i]     = (state[i] == COOL);
    end

    always_comb begin
        active_count = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            active_count = active_count + AC_W'(active[i]);
        end
    end

    // Free slots come from the registered count, so a slot released on this
    // edge is only handed out on the following cycle.
    always_comb begin
        int free_slots;
        int used;
        grant      = '0;
        free_slots = MAX_ACTIVE - int'(active_count);
        used       = 0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (want[i] && (used < free_slots)) begin
                grant[i] = 1'b1;
                used     = used + 1;
            end
        end
    end

endmodule

// File: doc/aircon_multizone_ctrl.md
# aircon_multizone_ctrl

Parametrised multi-zone successor to the single-zone heat/cool controller. It runs one idle/heat/cool/hold state machine per zone and derives heat and cool demand internally from sampled temperature, setpoint and hysteresis. Each zone has minimum-run and lockout timers. A global cap limits how many zones may run at once. It sits between the sensor sampling logic and the per-zone LED/actuator drivers.

## Interface
- N_ZONES, 4, number of independent zones (1..16)
- TEMP_W, 8, width of signed two's-complement temperature and setpoint
- MIN_RUN, 16, minimum cycles a zone stays in HEAT/COOL before it may exit normally
- LOCKOUT, 32, cycles spent in HOLD after leaving HEAT/COOL; 0 means go straight to IDLE
- MAX_ACTIVE, 2, maximum zones simultaneously in HEAT or COOL (1..N_ZONES)

Ports:
- clock  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- sample_valid  in  1  latch temp and setpoint on this cycle
- temp  in  N_ZONES*TEMP_W  per-zone temperature, zone i at [i*TEMP_W +: TEMP_W], signed
- setpoint  in  N_ZONES*TEMP_W  per-zone target, same packing, signed
- hyst  in  TEMP_W-1  unsigned hysteresis band, shared by all zones
- mode  in  2  global mode: 00 OFF, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO
- zone_en  in  N_ZONES  per-zone enable
- LR  out  N_ZONES  heating indicator per zone
- LG  out  N_ZONES  cooling indicator per zone
- active_count  out  $clog2(N_ZONES+1)  number of zones in HEAT or COOL

## Operation
- Reset (rst=0 at a clock edge):
  - all zones go to IDLE and all counters clear
  - temp and setpoint registers clear to 0
  - LR, LG and active_count all read 0
- Sampling: when sample_valid=1, temp and setpoint are captured into registers. The FSMs use only these registered values.
- Arithmetic: all comparisons are done sign-extended to TEMP_W+2 bits, so neither setpoint-hyst nor setpoint+hyst overflows.
- Demand:
  - heat_req = T < SP-hyst, and mode is HEAT_ONLY or AUTO.
  - cool_req = T > SP+hyst, and mode is COOL_ONLY or AUTO.
  - The two requests are mutually exclusive by construction.
- Per-zone states:
  - IDLE: LR=0, LG=0.
    - heat_req and granted → HEAT.
    - cool_req and granted → COOL.
    - Entering HEAT or COOL clears the counter.
  - HEAT: LR=1, LG=0.
    - Counter counts up, saturating at MIN_RUN.
    - Exit when T >= SP and counter == MIN_RUN → HOLD (or IDLE if LOCKOUT=0). Counter clears.
  - COOL: LR=0, LG=1.
    - Same as HEAT, with the exit condition T <= SP.
  - HOLD: LR=0, LG=0.
    - Counter counts to LOCKOUT, then → IDLE.
    - No demand is honoured while in HOLD.
- Force-off: mode=OFF or zone_en[i]=0 while a zone is in HEAT/COOL → HOLD on the next edge, ignoring MIN_RUN. An IDLE zone simply stays IDLE. The lockout still applies.
- Mode change mid-run (for example AUTO→HEAT_ONLY while COOL) does not force an exit. The zone exits through the normal condition.
- Grant (combinational, from current states):
  - free = MAX_ACTIVE - active_count.
  - IDLE zones with a request are granted in ascending zone index until free is exhausted.
  - Slots released on the same edge become usable only on the following cycle.
  - An ungranted zone stays IDLE and retries every cycle.
- active_count is the population count of zones in HEAT/COOL. It never exceeds MAX_ACTIVE.

## Timing
- LR and LG are a pure decode of the registered state, so they are glitch-free.
- Latency: with sample_valid high in cycle t, the registers update at edge t+1 and the state (and LEDs) update at edge t+2.
- MIN_RUN: a zone entering HEAT at edge e may first leave at edge e+MIN_RUN+1.
- HOLD: a zone entering HOLD at edge h returns to IDLE at edge h+LOCKOUT+1. The earliest re-entry to HEAT/COOL is the edge after that.
- Counter width is $clog2(max(MIN_RUN,LOCKOUT)+1).
- Reset has priority over every other input on the same edge. Reset mid-run drops LEDs at that edge, with no lockout.

## Structure
- aircon_pkg holds:
  - the zone state enum: IDLE=2'b00, HEAT=2'b01, COOL=2'b10, HOLD=2'b11 (values aligned with the legacy S0/S1/S2)
  - the mode encoding constants
- Sub-module aircon_zone_fsm, instantiated N_ZONES times in a generate loop:
  - contains the state register, dwell counter and demand comparators
  - takes grant and force_off as inputs
- The top level holds the sample registers, the grant priority chain and the active_count adder.

## Test plan
Default parameters are used unless stated.
- Reset with rst=0 for 3 cycles, all inputs toggling → LR=LG=0000 and active_count=0 throughout and on release.
- Zone0: SP=20, hyst=2, T=17, AUTO, sample → LR[0]=1 two edges after sample. Then T=20 sampled after 5 cycles → LR[0] holds until MIN_RUN is met. It drops at edge e+17. Zone0 then stays idle for 32 cycles even with T=10.
- Deadband check, zone0 SP=20, hyst=2: T=18 and T=22 → no action. T=23 → LG[0]=1. Same T=23 with mode=HEAT_ONLY → no action.
- All 4 zones at T=10, SP=20, same sample → only zones 0 and 1 heat, active_count=2. After zone0 exits, zone2 starts one cycle after the slot frees.
- zone_en[1]=0 while zone1 is COOL for 3 cycles → LG[1]=0 on the next edge (MIN_RUN overridden), then HOLD for 32 cycles.
- Boundary: TEMP_W=8, SP=-128, hyst=127, T=127 → cool_req is asserted with no overflow. SP=127, T=-128 → heat_req is asserted.
